// File: rtl/frame_strobe_gen_pkg.sv
// Shared types and header-word field layout for the configuration frame writer.
// Imported by the frame strobe generator and its sub-blocks.
package frame_cfg_pkg;

    typedef enum logic [1:0] {
        S_HDR    = 2'd0,
        S_DATA   = 2'd1,
        S_STROBE = 2'd2
    } state_t;

    localparam int unsigned HDR_FLAG_BIT = 31;
    localparam int unsigned HDR_COL_LSB  = 16;
    localparam int unsigned HDR_COL_W    = 8;
    localparam int unsigned HDR_CNT_LSB  = 8;
    localparam int unsigned HDR_CNT_W    = 5;
    localparam int unsigned HDR_FRM_LSB  = 0;
    localparam int unsigned HDR_FRM_W    = 5;

    typedef struct packed {
        logic [HDR_COL_W-1:0] col;
        logic [HDR_FRM_W-1:0] frame;
        logic [HDR_CNT_W:0]   count;
    } hdr_t;

    function automatic logic hdr_is_header(input logic [31:0] w);
        return w[HDR_FLAG_BIT];
    endfunction

    // Count field encodes count-1, so a 5-bit field covers 1..32 frames.
    function automatic hdr_t hdr_unpack(input logic [31:0] w);
        hdr_t h;
        h.col   = w[HDR_COL_LSB +: HDR_COL_W];
        h.frame = w[HDR_FRM_LSB +: HDR_FRM_W];
        h.count = {1'b0, w[HDR_CNT_LSB +: HDR_CNT_W]} + {{HDR_CNT_W{1'b0}}, 1'b1};
        return h;
    endfunction

endpackage

// File: rtl/frame_strobe_gen_if.sv
// Bitstream word handshake plus frame-write outputs toward the column selectors.
interface frame_strobe_gen_if #(
    parameter int unsigned MaxFramesPerCol  = 20,
    parameter int unsigned FrameSelectWidth = 5,
    parameter int unsigned FrameBitsPerRow  = 32
) ();

    logic [31:0]                 WriteData;
    logic                        WriteValid;
    logic                        WriteReady;
    logic [FrameBitsPerRow-1:0]  FrameData;
    logic [MaxFramesPerCol-1:0]  FrameAddress;
    logic [FrameSelectWidth-1:0] FrameSelect;
    logic                        FrameStrobe;

    modport master (
        output WriteData,
        output WriteValid,
        input  WriteReady,
        input  FrameData,
        input  FrameAddress,
        input  FrameSelect,
        input  FrameStrobe
    );

    modport slave (
        input  WriteData,
        input  WriteValid,
        output WriteReady,
        output FrameData,
        output FrameAddress,
        output FrameSelect,
        output FrameStrobe
    );

endinterface

// File: rtl/frame_index_decode.sv
// Binary frame index to one-hot frame address; all-zero when disabled or out of range.
module frame_index_decode #(
    parameter int unsigned OutWidth = 20,
    parameter int unsigned IdxWidth = 5
) (
    input  logic [IdxWidth-1:0] idx,
    input  logic                en,
    output logic [OutWidth-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < OutWidth; i++) begin
            onehot[i] = en && (32'(idx) == i);
        end
    end

endmodule

// File: rtl/frame_strobe_gen.sv
// Parses bitstream header/data words and issues one-cycle frame write strobes
// with column number and one-hot frame address.
module frame_strobe_gen
    import frame_cfg_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol  = 20,
    parameter int unsigned FrameSelectWidth = 5,
    parameter int unsigned NumCols          = 15,
    parameter int unsigned FrameBitsPerRow  = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    frame_strobe_gen_if.slave   bus,
    output logic                Busy,
    output logic                Error
);

    state_t                      state_q, state_d;
    logic [HDR_COL_W-1:0]        col_q, col_d;
    logic [HDR_FRM_W-1:0]        frame_q, frame_d;
    logic [HDR_CNT_W:0]          remaining_q, remaining_d;
    logic                        valid_q, valid_d;
    logic                        error_q, error_d;
    logic [FrameBitsPerRow-1:0]  frame_data_q, frame_data_d;
    logic [FrameSelectWidth-1:0] frame_select_q, frame_select_d;

    logic                        write_ready;
    logic                        accept;
    logic                        strobe;
    logic [MaxFramesPerCol-1:0]  frame_addr;
    hdr_t                        hdr;

    assign write_ready = (state_q != S_STROBE);
    assign accept      = bus.WriteValid && write_ready;
    assign hdr         = hdr_unpack(bus.WriteData);

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        frame_d        = frame_q;
        remaining_d    = remaining_q;
        valid_d        = valid_q;
        error_d        = error_q;
        frame_data_d   = frame_data_q;
        frame_select_d = frame_select_q;

        case (state_q)
            S_HDR: begin
                if (accept) begin
                    if (!hdr_is_header(bus.WriteData)) begin
                        error_d = 1'b1;
                    end else begin
                        col_d       = hdr.col;
                        frame_d     = hdr.frame;
                        remaining_d = hdr.count;
                        valid_d     = (32'(hdr.col) < NumCols) &&
                                      (32'(hdr.frame) < MaxFramesPerCol);
                        if (!valid_d) begin
                            error_d = 1'b1;
                        end
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    frame_data_d   = FrameBitsPerRow'(bus.WriteData);
                    frame_select_d = col_q[FrameSelectWidth-1:0];
                    state_d        = S_STROBE;
                end
            end

            S_STROBE: begin
                remaining_d = remaining_q - {{HDR_CNT_W{1'b0}}, 1'b1};
                if (remaining_q == {{HDR_CNT_W{1'b0}}, 1'b1}) begin
                    state_d = S_HDR;
                end else begin
                    // Column overrun disables the rest of the run; its words are still consumed.
                    if (32'(frame_q) == MaxFramesPerCol - 1) begin
                        frame_d = '0;
                        col_d   = col_q + {{(HDR_COL_W-1){1'b0}}, 1'b1};
                        if (32'(col_q) == NumCols - 1) begin
                            valid_d = 1'b0;
                            error_d = 1'b1;
                        end
                    end else begin
                        frame_d = frame_q + {{(HDR_FRM_W-1){1'b0}}, 1'b1};
                    end
                    state_d = S_DATA;
                end
            end

            default: begin
                state_d = S_HDR;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= S_HDR;
            col_q          <= '0;
            frame_q        <= '0;
            remaining_q    <= '0;
            valid_q        <= 1'b0;
            error_q        <= 1'b0;
            frame_data_q   <= '0;
            frame_select_q <= '0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            frame_q        <= frame_d;
            remaining_q    <= remaining_d;
            valid_q        <= valid_d;
            error_q        <= error_d;
            frame_data_q   <= frame_data_d;
            frame_select_q <= frame_select_d;
        end
    end

    // Strobe is decoded from registered state, so reset kills it in the same cycle.
    assign strobe = (state_q == S_STROBE) && valid_q;

    frame_index_decode #(
        .OutWidth (MaxFramesPerCol),
        .IdxWidth (HDR_FRM_W)
    ) u_decode (
        .idx    (frame_q),
        .en     (strobe),
        .onehot (frame_addr)
    );

    assign bus.WriteReady   = write_ready;
    assign bus.FrameData    = frame_data_q;
    assign bus.FrameSelect  = frame_select_q;
    assign bus.FrameStrobe  = strobe;
    assign bus.FrameAddress = frame_addr;
    assign Busy             = (state_q != S_HDR);
    assign Error            = error_q;

endmodule

// File: tb/tb_frame_strobe_gen.sv
// Directed bench for frame_strobe_gen: header parsing, bursts with column wrap,
// range errors, backpressure and mid-run reset.
module tb_frame_strobe_gen;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    logic Busy;
    logic Error;

    int checks   = 0;
    int failures = 0;

    frame_strobe_gen_if #(
        .MaxFramesPerCol  (20),
        .FrameSelectWidth (5),
        .FrameBitsPerRow  (32)
    ) bus ();

    frame_strobe_gen #(
        .MaxFramesPerCol  (20),
        .FrameSelectWidth (5),
        .NumCols          (15),
        .FrameBitsPerRow  (32)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus),
        .Busy  (Busy),
        .Error (Error)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]  sel;
        logic [19:0] addr;
        logic [31:0] data;
    } rec_t;

    rec_t log_q[$];
    int   strobe_cnt = 0;
    int   dbl_cnt    = 0;
    logic prev_strobe = 1'b0;

    always @(negedge CLK) begin
        if (bus.FrameStrobe === 1'b1) begin
            log_q.push_back('{bus.FrameSelect, bus.FrameAddress, bus.FrameData});
            strobe_cnt++;
            if (prev_strobe) dbl_cnt++;
        end
        prev_strobe = (bus.FrameStrobe === 1'b1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge; returns in the cycle after acceptance.
    task automatic xfer(input logic [31:0] w, input int unsigned idle);
        int unsigned n;
        for (int unsigned i = 0; i < idle; i++) @(negedge CLK);
        bus.WriteData  = w;
        bus.WriteValid = 1'b1;
        n = 0;
        while (bus.WriteReady !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (bus.WriteReady !== 1'b1) chk("xfer_ready_timeout", {63'd0, bus.WriteReady}, 64'd1);
        @(posedge CLK);
        @(negedge CLK);
        bus.WriteValid = 1'b0;
        bus.WriteData  = 32'h0;
    endtask

    task automatic chk_strobe(input string tag, input logic [4:0] sel,
                              input logic [19:0] addr, input logic [31:0] data);
        chk({tag, "_strobe"}, {63'd0, bus.FrameStrobe}, 64'd1);
        chk({tag, "_sel"},    {59'd0, bus.FrameSelect}, {59'd0, sel});
        chk({tag, "_addr"},   {44'd0, bus.FrameAddress}, {44'd0, addr});
        chk({tag, "_data"},   {32'd0, bus.FrameData}, {32'd0, data});
        chk({tag, "_ready"},  {63'd0, bus.WriteReady}, 64'd0);
    endtask

    task automatic chk_idle_out(input string tag);
        chk({tag, "_strobe"}, {63'd0, bus.FrameStrobe}, 64'd0);
        chk({tag, "_addr"},   {44'd0, bus.FrameAddress}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    logic [31:0] burst_data [4]  = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    logic [4:0]  burst_sel  [4]  = '{5'd2, 5'd2, 5'd3, 5'd3};
    logic [19:0] burst_addr [4]  = '{20'h40000, 20'h80000, 20'h00001, 20'h00002};
    logic [4:0]  bp_sel     [8]  = '{5'd5, 5'd5, 5'd5, 5'd5, 5'd6, 5'd6, 5'd6, 5'd6};
    logic [19:0] bp_addr    [8]  = '{20'h10000, 20'h20000, 20'h40000, 20'h80000,
                                     20'h00001, 20'h00002, 20'h00004, 20'h00008};
    int snap;

    initial begin
        bus.WriteData  = 32'h0;
        bus.WriteValid = 1'b0;

        // Reset values
        #1;
        chk("rst_ready", {63'd0, bus.WriteReady}, 64'd1);
        chk("rst_data",  {32'd0, bus.FrameData}, 64'd0);
        chk("rst_sel",   {59'd0, bus.FrameSelect}, 64'd0);
        chk_idle_out("rst");
        chk("rst_busy",  {63'd0, Busy}, 64'd0);
        chk("rst_error", {63'd0, Error}, 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        // Single frame
        xfer(32'h8003_0005, 0);
        chk("s1_hdr_busy",  {63'd0, Busy}, 64'd1);
        chk("s1_hdr_ready", {63'd0, bus.WriteReady}, 64'd1);
        xfer(32'hDEAD_BEEF, 0);
        chk_strobe("s1", 5'd3, 20'h00020, 32'hDEAD_BEEF);
        @(negedge CLK);
        chk_idle_out("s1_after");
        chk("s1_after_busy",  {63'd0, Busy}, 64'd0);
        chk("s1_after_error", {63'd0, Error}, 64'd0);
        chk("s1_after_data",  {32'd0, bus.FrameData}, 64'hDEAD_BEEF);

        // Burst of 4 wrapping from frame 19 into the next column
        xfer(32'h8002_0312, 0);
        for (int i = 0; i < 4; i++) begin
            xfer(burst_data[i], 0);
            chk_strobe($sformatf("burst%0d", i), burst_sel[i], burst_addr[i], burst_data[i]);
        end
        @(negedge CLK);
        chk_idle_out("burst_end");
        chk("burst_end_busy", {63'd0, Busy}, 64'd0);

        // Backpressure: random idle gaps during an 8-frame burst
        log_q.delete();
        xfer(32'h8005_0710, $urandom_range(0, 3));
        for (int i = 0; i < 8; i++) begin
            xfer(32'hB000_0000 + 32'(i), $urandom_range(0, 3));
        end
        @(negedge CLK);
        #1;
        chk("bp_count", 64'(log_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            chk($sformatf("bp%0d_sel", i),  {59'd0, log_q[i].sel},  {59'd0, bp_sel[i]});
            chk($sformatf("bp%0d_addr", i), {44'd0, log_q[i].addr}, {44'd0, bp_addr[i]});
            chk($sformatf("bp%0d_data", i), {32'd0, log_q[i].data}, 64'hB000_0000 + 64'(i));
        end
        chk("bp_error", {63'd0, Error}, 64'd0);

        // Reset after 2 of 5 frames
        xfer(32'h8000_0400, 0);
        xfer(32'hC000_0000, 0);
        chk_strobe("mr0", 5'd0, 20'h00001, 32'hC000_0000);
        xfer(32'hC000_0001, 0);
        chk_strobe("mr1", 5'd0, 20'h00002, 32'hC000_0001);
        #1;
        snap = strobe_cnt;
        RESET = 1'b1;
        #1;
        chk_idle_out("mr_rst");
        chk("mr_rst_data",  {32'd0, bus.FrameData}, 64'd0);
        chk("mr_rst_sel",   {59'd0, bus.FrameSelect}, 64'd0);
        chk("mr_rst_ready", {63'd0, bus.WriteReady}, 64'd1);
        chk("mr_rst_busy",  {63'd0, Busy}, 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (6) @(negedge CLK);
        #1;
        chk("mr_no_strobe", 64'(strobe_cnt), 64'(snap));
        chk("mr_idle_busy", {63'd0, Busy}, 64'd0);
        xfer(32'h8004_0003, 0);
        xfer(32'hC0DE_0004, 0);
        chk_strobe("mr_new", 5'd4, 20'h00008, 32'hC0DE_0004);

        // Out-of-range column: words consumed, no strobe
        @(negedge CLK);
        #1;
        snap = strobe_cnt;
        xfer(32'h800F_0100, 0);
        chk("oor_error", {63'd0, Error}, 64'd1);
        chk("oor_busy",  {63'd0, Busy}, 64'd1);
        xfer(32'h1111_1111, 0);
        chk_idle_out("oor_d0");
        xfer(32'h2222_2222, 0);
        chk_idle_out("oor_d1");
        @(negedge CLK);
        #1;
        chk("oor_no_strobe", 64'(strobe_cnt), 64'(snap));
        chk("oor_end_busy",  {63'd0, Busy}, 64'd0);

        // Column overrun from (14,19): one strobe then suppression
        do_reset();
        chk("ov_pre_error", {63'd0, Error}, 64'd0);
        xfer(32'h800E_0113, 0);
        chk("ov_hdr_error", {63'd0, Error}, 64'd0);
        xfer(32'h3333_3333, 0);
        chk_strobe("ov0", 5'd14, 20'h80000, 32'h3333_3333);
        chk("ov0_error", {63'd0, Error}, 64'd0);
        @(negedge CLK);
        chk("ov_error", {63'd0, Error}, 64'd1);
        chk("ov_busy",  {63'd0, Busy}, 64'd1);
        xfer(32'h4444_4444, 0);
        chk_idle_out("ov1");
        chk("ov1_data", {32'd0, bus.FrameData}, 64'h4444_4444);
        chk("ov1_sel",  {59'd0, bus.FrameSelect}, 64'd15);
        @(negedge CLK);
        chk("ov_end_busy", {63'd0, Busy}, 64'd0);

        // Bad header discarded, then a normal run
        do_reset();
        xfer(32'h1234_5678, 0);
        chk("bad_error", {63'd0, Error}, 64'd1);
        chk("bad_busy",  {63'd0, Busy}, 64'd0);
        chk("bad_ready", {63'd0, bus.WriteReady}, 64'd1);
        xfer(32'h8001_0000, 0);
        chk("bad_hdr_busy", {63'd0, Busy}, 64'd1);
        xfer(32'h5555_AAAA, 0);
        chk_strobe("bad_next", 5'd1, 20'h00001, 32'h5555_AAAA);
        @(negedge CLK);
        chk("bad_sticky", {63'd0, Error}, 64'd1);

        #1;
        chk("strobe_width", 64'(dbl_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
